csr_file_m: RTL and testbench

- Machine-mode control/status register file for the RV32 core; successor to the single-cycle CSR bank.
- Adds CSRRxI immediate forms, trap entry/MRET sequencing and WARL legalisation.
- Adds parametrised cycle/instret counters, interrupt enable/pending logic and illegal-access detection.
- Sits in the EX stage; trap/return controls come from the pipeline controller, redirect PCs go to fetch.

---
 rtl/csr_file_m_pkg.sv | 47 ++++
 rtl/csr_counter.sv | 57 +++++
 rtl/csr_file_m.sv | 185 ++++++++++++++++++
 tb/tb_csr_file_m.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_file_m_pkg.sv
// rtl/csr_file_m_pkg.sv - shared CSR addresses, funct3 encodings and bit positions
package csr_file_m_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  // funct3[1:0]; funct3[2] separately selects the zimm source
  typedef enum logic [1:0] {
    CSR_OP_ILL = 2'b00,
    CSR_OP_RW  = 2'b01,
    CSR_OP_RS  = 2'b10,
    CSR_OP_RC  = 2'b11
  } csr_op_e;

  localparam int IRQ_CAUSE_MSI = 3;
  localparam int IRQ_CAUSE_MTI = 7;
  localparam int IRQ_CAUSE_MEI = 11;

  // mie/mip bit positions coincide with the interrupt cause codes
  localparam int MIE_MSIE_BIT = IRQ_CAUSE_MSI;
  localparam int MIE_MTIE_BIT = IRQ_CAUSE_MTI;
  localparam int MIE_MEIE_BIT = IRQ_CAUSE_MEI;
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;
  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;
  localparam logic [31:0] MIE_MASK      = (32'h1 << MIE_MSIE_BIT) |
                                          (32'h1 << MIE_MTIE_BIT) |
                                          (32'h1 << MIE_MEIE_BIT);

endpackage

// File: rtl/csr_counter.sv
// rtl/csr_counter.sv - wrapping event counter with independently writable halves
module csr_counter #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            wr_lo,
  input  logic            wr_hi,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rd_lo,
  output logic [XLEN-1:0] rd_hi
);

  generate
    if (CNT_WIDTH > XLEN) begin : g_wide
      logic [XLEN-1:0]           lo_q;
      logic [CNT_WIDTH-XLEN-1:0] hi_q;

      // a write to either half replaces it and swallows that cycle's increment
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lo_q <= '0;
          hi_q <= '0;
        end else if (wr_lo) begin
          lo_q <= wdata;
        end else if (wr_hi) begin
          hi_q <= wdata[CNT_WIDTH-XLEN-1:0];
        end else if (inc) begin
          {hi_q, lo_q} <= {hi_q, lo_q} + CNT_WIDTH'(1);
        end
      end

      assign rd_lo = lo_q;
      assign rd_hi = XLEN'(hi_q);
    end else begin : g_narrow
      logic [XLEN-1:0] cnt_q;
      logic            unused_wr_hi;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (wr_lo) begin
          cnt_q <= wdata;
        end else if (inc) begin
          cnt_q <= cnt_q + XLEN'(1);
        end
      end

      assign unused_wr_hi = wr_hi;
      assign rd_lo = cnt_q;
      assign rd_hi = '0;
    end
  endgenerate

endmodule

// File: rtl/csr_file_m.sv
// rtl/csr_file_m.sv - machine-mode CSR file with trap/MRET sequencing and counters
// Optional CSR_FILE_MTVAL_EN adds the trap_tval port and the mtval CSR.
module csr_file_m
  import csr_file_m_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              CNT_WIDTH   = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_en,
  input  logic [11:0]     csr_addr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      zimm,
  input  logic            rs1_is_x0,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            instret_inc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
`ifdef CSR_FILE_MTVAL_EN
  input  logic [XLEN-1:0] trap_tval,
`endif
  input  logic            mret,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mepc_out,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_sw,
  output logic            irq_pending
);

  localparam bit HAS_HI = (CNT_WIDTH > XLEN);

  csr_op_e         op;
  logic [XLEN-1:0] src, old_val, new_val, mip_val, tvec_base;
  logic            implemented, read_only, wr_attempt, illegal, do_write;
  logic            mstatus_mie, mstatus_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [XLEN-1:0] cyc_lo, cyc_hi, ins_lo, ins_hi;
`ifdef CSR_FILE_MTVAL_EN
  logic [XLEN-1:0] mtval_q;
`endif

  assign op  = csr_op_e'(funct3[1:0]);
  assign src = funct3[2] ? {{(XLEN-5){1'b0}}, zimm} : rs1_data;

  always_comb begin
    mip_val = '0;
    mip_val[MIE_MSIE_BIT] = irq_sw;
    mip_val[MIE_MTIE_BIT] = irq_timer;
    mip_val[MIE_MEIE_BIT] = irq_ext;
  end

  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    case (csr_addr)
      CSR_MSTATUS: begin
        old_val = MSTATUS_MPP_M;
        old_val[MSTATUS_MIE_BIT]  = mstatus_mie;
        old_val[MSTATUS_MPIE_BIT] = mstatus_mpie;
      end
      CSR_MISA:                  old_val = MISA_VALUE;
      CSR_MIE:                   old_val = mie_q;
      CSR_MTVEC:                 old_val = mtvec_q;
      CSR_MSCRATCH:              old_val = mscratch_q;
      CSR_MEPC:                  old_val = mepc_q;
      CSR_MCAUSE:                old_val = mcause_q;
`ifdef CSR_FILE_MTVAL_EN
      CSR_MTVAL:                 old_val = mtval_q;
`endif
      CSR_MIP:                   old_val = mip_val;
      CSR_MCYCLE, CSR_CYCLE:     old_val = cyc_lo;
      CSR_MINSTRET, CSR_INSTRET: old_val = ins_lo;
      CSR_MCYCLEH, CSR_CYCLEH: begin
        old_val     = cyc_hi;
        implemented = HAS_HI;
      end
      CSR_MINSTRETH, CSR_INSTRETH: begin
        old_val     = ins_hi;
        implemented = HAS_HI;
      end
      default:                   implemented = 1'b0;
    endcase
  end

  // RS/RC with a zero source are pure reads, so they may target read-only CSRs
  assign read_only  = (csr_addr[11:10] == 2'b11) || (csr_addr == CSR_MISA) ||
                      (csr_addr == CSR_MIP);
  assign wr_attempt = (op == CSR_OP_RW) || ((op != CSR_OP_ILL) && !rs1_is_x0);
  assign illegal    = csr_en && (!implemented || (op == CSR_OP_ILL) ||
                                 (wr_attempt && read_only));
  assign do_write   = csr_en && wr_attempt && !illegal && !trap_valid && !mret;

  always_comb begin
    case (op)
      CSR_OP_RW: new_val = src;
      CSR_OP_RS: new_val = old_val | src;
      CSR_OP_RC: new_val = old_val & ~src;
      default:   new_val = old_val;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RESET & ~XLEN'(2);
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
`ifdef CSR_FILE_MTVAL_EN
      mtval_q      <= '0;
`endif
    end else if (trap_valid) begin
      mepc_q       <= trap_pc & ~XLEN'(3);
      mcause_q     <= trap_cause;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
`ifdef CSR_FILE_MTVAL_EN
      mtval_q      <= trap_tval;
`endif
    end else if (mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (do_write) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie  <= new_val[MSTATUS_MIE_BIT];
          mstatus_mpie <= new_val[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_q      <= new_val & MIE_MASK;
        CSR_MTVEC:    mtvec_q    <= new_val & ~XLEN'(2);
        CSR_MSCRATCH: mscratch_q <= new_val;
        CSR_MEPC:     mepc_q     <= new_val & ~XLEN'(3);
        CSR_MCAUSE:   mcause_q   <= new_val;
`ifdef CSR_FILE_MTVAL_EN
        CSR_MTVAL:    mtval_q    <= new_val;
`endif
        default: ;
      endcase
    end
  end

  csr_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (do_write && (csr_addr == CSR_MCYCLE)),
    .wr_hi (do_write && (csr_addr == CSR_MCYCLEH)),
    .wdata (new_val),
    .rd_lo (cyc_lo),
    .rd_hi (cyc_hi)
  );

  csr_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instret_inc),
    .wr_lo (do_write && (csr_addr == CSR_MINSTRET)),
    .wr_hi (do_write && (csr_addr == CSR_MINSTRETH)),
    .wdata (new_val),
    .rd_lo (ins_lo),
    .rd_hi (ins_hi)
  );

  // vectored mode offsets only asynchronous interrupts
  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  always_comb begin
    trap_vector = tvec_base;
    if (mtvec_q[0] && trap_cause[XLEN-1])
      trap_vector = tvec_base + {{(XLEN-7){1'b0}}, trap_cause[4:0], 2'b00};
  end

  assign csr_rdata   = old_val;
  assign csr_illegal = illegal;
  assign mepc_out    = mepc_q;
  assign irq_pending = mstatus_mie && |(mie_q & mip_val);

endmodule

// File: tb/tb_csr_file_m.sv
// tb/tb_csr_file_m.sv - directed and random checks of csr_file_m against a reference model
module tb_csr_file_m;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_en;
  logic [11:0] csr_addr;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [4:0]  zimm;
  logic        rs1_is_x0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        instret_inc;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;
  logic        irq_ext, irq_timer, irq_sw;
  logic        irq_pending;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_mie, m_mpie;
  logic [31:0] m_mie_reg, m_mtvec, m_scratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins;

  always #5 clk = ~clk;

  csr_file_m dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_en      (csr_en),
    .csr_addr    (csr_addr),
    .funct3      (funct3),
    .rs1_data    (rs1_data),
    .zimm        (zimm),
    .rs1_is_x0   (rs1_is_x0),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .instret_inc (instret_inc),
    .trap_valid  (trap_valid),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
`ifdef CSR_FILE_MTVAL_EN
    .trap_tval   (trap_tval),
`endif
    .mret        (mret),
    .trap_vector (trap_vector),
    .mepc_out    (mepc_out),
    .irq_ext     (irq_ext),
    .irq_timer   (irq_timer),
    .irq_sw      (irq_sw),
    .irq_pending (irq_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mie_reg = 0; m_mtvec = 0; m_scratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_cyc = 0; m_ins = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a, output bit impl);
    impl = 1;
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie_reg;
      12'h305: return m_mtvec;
      12'h340: return m_scratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
`ifdef CSR_FILE_MTVAL_EN
      12'h343: return m_mtval;
`endif
      12'h344: return (32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_sw) << 3);
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      default: begin impl = 0; return 32'h0; end
    endcase
  endfunction

  function automatic bit m_wants_write();
    return (funct3[1:0] == 2'b01) || (funct3[1:0] != 2'b00 && !rs1_is_x0);
  endfunction

  function automatic bit m_illegal();
    bit impl, ro;
    logic [31:0] v;
    v  = m_read(csr_addr, impl);
    ro = (csr_addr[11:10] == 2'b11) || (csr_addr == 12'h301) || (csr_addr == 12'h344);
    return csr_en && (!impl || funct3[1:0] == 2'b00 || (m_wants_write() && ro));
  endfunction

  function automatic logic [31:0] m_vector();
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
    if (m_mtvec[0] && trap_cause[31]) return base + 32'd4 * trap_cause[4:0];
    return base;
  endfunction

  task automatic model_check();
    bit impl;
    logic [31:0] exp_rd, mipv;
    exp_rd = m_read(csr_addr, impl);
    mipv   = m_read(12'h344, impl);
    if (csr_en) check("rdata", csr_rdata, exp_rd);
    check("illegal", 32'(csr_illegal), 32'(m_illegal()));
    check("trap_vector", trap_vector, m_vector());
    check("mepc_out", mepc_out, m_mepc);
    check("irq_pending", 32'(irq_pending), 32'(m_mie && ((m_mie_reg & mipv) != 0)));
  endtask

  task automatic model_update();
    bit impl, cw, iw;
    logic [31:0] old, src, nv;
    old = m_read(csr_addr, impl);
    src = funct3[2] ? 32'(zimm) : rs1_data;
    case (funct3[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      2'b11:   nv = old & ~src;
      default: nv = old;
    endcase
    cw = 0; iw = 0;
    if (trap_valid) begin
      m_mepc = trap_pc & ~32'h3;
      m_mcause = trap_cause;
      m_mpie = m_mie;
      m_mie = 0;
      m_mtval = trap_tval;
    end else if (mret) begin
      m_mie = m_mpie;
      m_mpie = 1;
    end else if (csr_en && m_wants_write() && !m_illegal()) begin
      case (csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie_reg = nv & 32'h888;
        12'h305: m_mtvec = nv & ~32'h2;
        12'h340: m_scratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: begin m_cyc[31:0]  = nv; cw = 1; end
        12'hB80: begin m_cyc[63:32] = nv; cw = 1; end
        12'hB02: begin m_ins[31:0]  = nv; iw = 1; end
        12'hB82: begin m_ins[63:32] = nv; iw = 1; end
        default: ;
      endcase
    end
    if (!cw) m_cyc = m_cyc + 64'd1;
    if (!iw && instret_inc) m_ins = m_ins + 64'd1;
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic idle();
    csr_en = 0; csr_addr = 0; funct3 = 0; rs1_data = 0; zimm = 0; rs1_is_x0 = 1;
    trap_valid = 0; mret = 0; instret_inc = 0;
  endtask

  task automatic csr(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] rs, input bit x0);
    csr_en = 1; csr_addr = a; funct3 = f3; rs1_data = rs; zimm = rs[4:0]; rs1_is_x0 = x0;
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 21))
      0: return 12'h300;  1: return 12'h301;  2: return 12'h304;  3: return 12'h305;
      4: return 12'h340;  5: return 12'h341;  6: return 12'h342;  7: return 12'h343;
      8: return 12'h344;  9: return 12'hB00; 10: return 12'hB02; 11: return 12'hB80;
      12: return 12'hB82; 13: return 12'hC00; 14: return 12'hC02; 15: return 12'hC80;
      16: return 12'hC82; 17: return 12'h7C0; 18: return 12'h000; 19: return 12'h3FF;
      20: return 12'h300;
      default: return 12'h304;
    endcase
  endfunction

  initial begin
    rst_n = 0;
    idle();
    trap_cause = 0; trap_pc = 0; trap_tval = 0;
    irq_ext = 0; irq_timer = 0; irq_sw = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // reset values and free-running cycle count
    csr(12'hB00, 3'b010, 0, 1);
    settle();
    check("rst_mcycle", csr_rdata, 32'h0);
    check("rst_illegal", 32'(csr_illegal), 32'h0);
    check("rst_irq_pending", 32'(irq_pending), 32'h0);
    advance();
    csr(12'h305, 3'b010, 0, 1); settle(); check("rst_mtvec", csr_rdata, 32'h0); advance();
    csr(12'h300, 3'b010, 0, 1); settle(); check("rst_mstatus", csr_rdata, 32'h1800); advance();
    idle();
    repeat (7) step();
    csr(12'hC00, 3'b010, 0, 1);
    settle();
    check("cycle_after_10", csr_rdata, 32'd10);
    check("cycle_read_legal", 32'(csr_illegal), 32'h0);
    advance();

    // mscratch RW / RSI with zero / RC
    csr(12'h340, 3'b001, 32'hDEAD_BEEF, 0); step();
    csr(12'h340, 3'b110, 0, 1); settle(); check("rsi_x0_rdata", csr_rdata, 32'hDEAD_BEEF); advance();
    csr(12'h340, 3'b011, 32'h0000_FFFF, 0); settle(); check("rc_old", csr_rdata, 32'hDEAD_BEEF); advance();
    csr(12'h340, 3'b010, 0, 1); settle(); check("rc_result", csr_rdata, 32'hDEAD_0000); advance();

    // illegal accesses
    csr(12'hC00, 3'b001, 32'd5, 0); settle(); check("ro_write_illegal", 32'(csr_illegal), 32'h1); advance();
    csr(12'hC00, 3'b010, 0, 1); step();
    csr(12'h7C0, 3'b010, 0, 1);
    settle();
    check("unimpl_rdata", csr_rdata, 32'h0);
    check("unimpl_illegal", 32'(csr_illegal), 32'h1);
    advance();

    // vectored trap and return
    csr(12'h305, 3'b001, 32'h1001, 0); step();
    csr(12'h300, 3'b110, 32'h8, 0); step();
    idle();
    trap_valid = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h2006; trap_tval = 32'h55;
    settle(); check("trap_vector_vec", trap_vector, 32'h101C); advance();
    idle();
    csr(12'h341, 3'b010, 0, 1); settle(); check("trap_mepc", csr_rdata, 32'h2004); advance();
    csr(12'h300, 3'b010, 0, 1); settle(); check("trap_mstatus", csr_rdata, 32'h1880); advance();
    idle(); mret = 1; step(); idle();
    csr(12'h300, 3'b010, 0, 1);
    settle();
    check("mret_mstatus", csr_rdata, 32'h1888);
    check("mret_mepc_out", mepc_out, 32'h2004);
    advance();

    // interrupt pending
    csr(12'h304, 3'b001, 32'h80, 0); step();
    idle(); irq_timer = 1;
    settle(); check("irq_pending_set", 32'(irq_pending), 32'h1); advance();
    csr(12'h300, 3'b111, 32'h8, 0); step();
    idle(); settle(); check("irq_pending_clr", 32'(irq_pending), 32'h0); advance();
    irq_timer = 0;

    // trap beats mret beats CSR write
    csr(12'h341, 3'b001, 32'h40, 0);
    trap_valid = 1; mret = 1; trap_pc = 32'h3000; trap_cause = 32'h2;
    step();
    idle();
    csr(12'h341, 3'b010, 0, 1); settle(); check("priority_mepc", csr_rdata, 32'h3000); advance();

    // 64-bit wrap through a write of all ones
    csr(12'hB80, 3'b001, 32'hFFFF_FFFF, 0); step();
    csr(12'hB00, 3'b001, 32'hFFFF_FFFF, 0); step();
    csr(12'hB00, 3'b010, 0, 1); settle(); check("cnt_all_ones", csr_rdata, 32'hFFFF_FFFF); advance();
    csr(12'hB80, 3'b010, 0, 1); settle(); check("cnt_wrap_hi", csr_rdata, 32'h0); advance();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      csr_en   = ($urandom_range(0, 3) != 0);
      csr_addr = pick_addr();
      funct3   = 3'($urandom_range(0, 7));
      if (funct3[2]) begin
        zimm      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        rs1_is_x0 = (zimm == 5'd0);
        rs1_data  = $urandom;
      end else begin
        rs1_is_x0 = ($urandom_range(0, 3) == 0);
        rs1_data  = rs1_is_x0 ? 32'h0 : $urandom;
        zimm      = 5'($urandom);
      end
      trap_valid  = ($urandom_range(0, 19) == 0);
      trap_cause  = $urandom & 32'h8000_001F;
      trap_pc     = $urandom;
      trap_tval   = $urandom;
      mret        = ($urandom_range(0, 9) == 0);
      instret_inc = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        irq_ext = 1'($urandom); irq_timer = 1'($urandom); irq_sw = 1'($urandom);
      end
      step();
    end

    // asynchronous reset in the middle of a trap
    idle();
    trap_valid = 1; trap_pc = 32'h1234_5678; trap_cause = 32'h8000_0003;
    @(negedge clk);
    rst_n = 0;
    #1;
    check("areset_mepc_out", mepc_out, 32'h0);
    check("areset_irq_pending", 32'(irq_pending), 32'h0);
    check("areset_trap_vector", trap_vector, 32'h0);
    @(posedge clk);
    #1;
    check("areset_no_trap", mepc_out, 32'h0);
    csr(12'h342, 3'b010, 0, 1); #1 check("areset_mcause", csr_rdata, 32'h0);
    csr(12'h300, 3'b010, 0, 1); #1 check("areset_mstatus", csr_rdata, 32'h1800);
    model_reset();
    idle();
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 200; i++) begin
      csr_en = 1; csr_addr = pick_addr(); funct3 = 3'b010; rs1_is_x0 = 1; rs1_data = 0;
      instret_inc = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
